// File: rtl/uart_hex_tx.sv
// uart_hex_tx: UART 8N1 transmitter that sends one byte as two ASCII hex
// characters ('0'-'9', 'A'-'F'), most significant nibble first.
// Optional feature macro UART_HEX_TX_CRLF_EN: when defined, every message is
// followed by CR (0x0D) and LF (0x0A), giving four characters per message.
// All outputs are registered; reset is synchronous and active-low.
module uart_hex_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic [7:0] i_Byte,
    output logic       o_UART_TX,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_HEX_TX_CRLF_EN
    localparam int CHAR_W  = 2;
    localparam int N_CHARS = 4;
`else
    localparam int CHAR_W  = 1;
    localparam int N_CHARS = 2;
`endif
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(N_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [CHAR_W-1:0]  char_idx_q, char_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         byte_q, byte_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Uppercase ASCII hex digit for a nibble: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

    // Character at position idx of the message built from value.
    function automatic logic [7:0] msg_char(input logic [CHAR_W-1:0] idx,
                                            input logic [7:0]        value);
        msg_char = hex_ascii(value[7:4]);
        case (idx)
            CHAR_W'(1): msg_char = hex_ascii(value[3:0]);
`ifdef UART_HEX_TX_CRLF_EN
            CHAR_W'(2): msg_char = 8'h0D;
            CHAR_W'(3): msg_char = 8'h0A;
`endif
            default: ;
        endcase
    endfunction

    // State register and datapath registers; reset parks the line high in IDLE.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; output values are computed one cycle ahead so the
    // registered line changes exactly on each bit boundary.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_Start) begin
                    byte_d     = i_Byte;
                    shift_d    = msg_char(CHAR_W'(0), i_Byte);
                    char_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_cnt_d = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = START_BIT;
                end
            end

            START_BIT: begin
                if (baud_cnt_q == CNT_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = DATA_BITS;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            DATA_BITS: begin
                if (baud_cnt_q == CNT_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            STOP_BIT: begin
                if (baud_cnt_q == CNT_LAST) begin
                    baud_cnt_d = '0;
                    if (char_idx_q != CHAR_LAST) begin
                        char_idx_d = char_idx_q + CHAR_W'(1);
                        shift_d    = msg_char(char_idx_q + CHAR_W'(1), byte_q);
                        tx_d       = 1'b0;
                        state_d    = START_BIT;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_UART_TX = tx_q;
    assign o_Busy    = busy_q;
    assign o_Done    = done_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Testbench for uart_hex_tx. Honours UART_HEX_TX_CRLF_EN for message length.
// One instance runs at 4 clocks per bit for most scenarios, a second at the
// default 217 clocks per bit for the bit-timing scenario.
module tb_uart_hex_tx;

`ifdef UART_HEX_TX_CRLF_EN
    localparam int N_CHARS = 4;
`else
    localparam int N_CHARS = 2;
`endif
    localparam int CPB      = 4;
    localparam int CPB_SLOW = 217;
    localparam int MSG_LEN  = N_CHARS * 10 * CPB;
    localparam int MSG_SLOW = N_CHARS * 10 * CPB_SLOW;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       start_fast, start_slow;
    logic [7:0] byte_fast, byte_slow;
    logic       tx_fast, busy_fast, done_fast;
    logic       tx_slow, busy_slow, done_slow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] value;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut_fast (
        .i_Clk     (clk),
        .i_Rst_L   (rst_l),
        .i_Start   (start_fast),
        .i_Byte    (byte_fast),
        .o_UART_TX (tx_fast),
        .o_Busy    (busy_fast),
        .o_Done    (done_fast)
    );

    uart_hex_tx #(.CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .i_Clk     (clk),
        .i_Rst_L   (rst_l),
        .i_Start   (start_slow),
        .i_Byte    (byte_slow),
        .o_UART_TX (tx_slow),
        .o_Busy    (busy_slow),
        .o_Done    (done_slow)
    );

    // Reference: ASCII hex digit from plain arithmetic.
    function automatic logic [7:0] refHex(input logic [3:0] n);
        int v;
        v = int'(n);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + v - 10);
    endfunction

    // Reference: character idx of the message for byte b.
    function automatic logic [7:0] refChar(input logic [7:0] b, input int idx);
        case (idx)
            0:       return refHex(b[7:4]);
            1:       return refHex(b[3:0]);
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Reference: expected line level p cycles after the start edge.
    function automatic logic refLine(input logic [7:0] b, input int p, input int cpb);
        int frame;
        int slot;
        logic [7:0] c;
        frame = p / (10 * cpb);
        slot  = (p % (10 * cpb)) / cpb;
        c     = refChar(b, frame);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return c[slot-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic [7:0] value);
        start_fast = start;
        byte_fast  = value;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Sends b on the fast instance and checks the whole waveform. Optional
    // i_Start hold window while busy, and optional chaining into the next
    // message (i_Start left high through the done cycle).
    task automatic runMessage(input logic [7:0] b, input int hold_from, input int hold_to,
                              input logic [7:0] hold_byte, input bit chain,
                              input logic [7:0] chain_byte, input string tag,
                              output logic [31:0] decoded);
        logic line[$];
        int   wave_err;
        int   busy_cycles;
        int   base;
        logic [7:0] ch;
        wave_err    = 0;
        busy_cycles = 0;
        decoded     = '0;
        applyStimulus(1'b1, b);
        tick();
        for (int k = 1; k <= MSG_LEN; k++) begin
            line.push_back(tx_fast);
            if (tx_fast !== refLine(b, k - 1, CPB) || done_fast !== 1'b0) wave_err++;
            if (busy_fast === 1'b1) busy_cycles++;
            if (chain && k >= MSG_LEN - 3) applyStimulus(1'b1, chain_byte);
            else if (k >= hold_from && k <= hold_to) applyStimulus(1'b1, hold_byte);
            else applyStimulus(1'b0, 8'($urandom));
            tick();
        end
        checkOutput({tag, "_wave_errors"}, wave_err, 0);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, MSG_LEN);
        checkOutput({tag, "_done_tx_busy"}, {29'd0, done_fast, tx_fast, busy_fast}, 32'b110);
        for (int c = 0; c < N_CHARS; c++) begin
            base = c * 10 * CPB;
            for (int i = 0; i < 8; i++) ch[i] = line[base + (i + 1) * CPB + CPB / 2];
            decoded[c*8 +: 8] = ch;
            checkOutput($sformatf("%s_char%0d", tag, c), ch, refChar(b, c));
        end
        if (!chain) begin
            applyStimulus(1'b0, 8'h00);
            tick();
            checkOutput({tag, "_done_one_cycle"}, done_fast, 1'b0);
        end
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #3_000_000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    // Main test sequence.
    initial begin
        logic [31:0] dec;
        logic [7:0]  cur, nxt;
        bit          ch_en;
        int          err_cnt, edge_err, busy_cnt;
        logic        prev_tx;

        vecs[0] = '{8'h5A, 8'h35, 8'h41};
        vecs[1] = '{8'h09, 8'h30, 8'h39};
        vecs[2] = '{8'hAF, 8'h41, 8'h46};
        vecs[3] = '{8'hF0, 8'h46, 8'h30};
        vecs[4] = '{8'h00, 8'h30, 8'h30};
        vecs[5] = '{8'hFF, 8'h46, 8'h46};

        // Reset with i_Start high: reset must win.
        rst_l      = 1'b0;
        start_slow = 1'b0;
        byte_slow  = 8'h00;
        applyStimulus(1'b1, 8'h5A);
        repeat (3) tick();
        checkOutput("reset_tx", tx_fast, 1'b1);
        checkOutput("reset_busy", busy_fast, 1'b0);
        checkOutput("reset_done", done_fast, 1'b0);
        applyStimulus(1'b0, 8'h00);
        rst_l = 1'b1;
        repeat (2) tick();
        checkOutput("idle_tx", tx_fast, 1'b1);

        // Table-driven mapping vectors.
        for (int i = 0; i < 6; i++) begin
            runMessage(vecs[i].value, 0, -1, 8'h00, 1'b0, 8'h00,
                       $sformatf("vec%0d", i), dec);
            checkOutput($sformatf("vec%0d_c0", i), dec[7:0], vecs[i].c0);
            checkOutput($sformatf("vec%0d_c1", i), dec[15:8], vecs[i].c1);
        end

        // Busy lockout: i_Start held mid-message, then held through done.
        runMessage(8'h12, 20, 29, 8'h34, 1'b1, 8'h34, "lock12", dec);
        checkOutput("lock12_text", dec[15:0], 16'h3231);
        runMessage(8'h34, 0, -1, 8'h00, 1'b0, 8'h00, "lock34", dec);
        checkOutput("lock34_text", dec[15:0], 16'h3433);

        // Reset during DATA_BITS of char1.
        applyStimulus(1'b1, 8'h5A);
        tick();
        for (int k = 1; k <= 13 * CPB; k++) begin
            applyStimulus(1'b0, 8'h00);
            tick();
        end
        rst_l = 1'b0;
        tick();
        checkOutput("midrst_tx", tx_fast, 1'b1);
        checkOutput("midrst_busy", busy_fast, 1'b0);
        checkOutput("midrst_done", done_fast, 1'b0);
        tick();
        rst_l   = 1'b1;
        err_cnt = 0;
        for (int k = 0; k < 2 * MSG_LEN; k++) begin
            if (done_fast !== 1'b0 || busy_fast !== 1'b0 || tx_fast !== 1'b1) err_cnt++;
            tick();
        end
        checkOutput("midrst_quiet", err_cnt, 0);
        runMessage(8'hC3, 0, -1, 8'h00, 1'b0, 8'h00, "postrst", dec);

        // Randomized bytes against the reference model, random chaining.
        cur = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            nxt   = 8'($urandom);
            ch_en = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            runMessage(cur, 0, -1, 8'h00, ch_en, nxt, $sformatf("rnd%0d", i), dec);
            cur = nxt;
        end

        // Bit timing at 217 clocks per bit, sending 0x00.
        start_slow = 1'b1;
        byte_slow  = 8'h00;
        tick();
        start_slow = 1'b0;
        checkOutput("slow_start_edge", tx_slow, 1'b0);
        err_cnt  = 0;
        edge_err = 0;
        busy_cnt = 0;
        prev_tx  = 1'b1;
        for (int k = 1; k <= MSG_SLOW; k++) begin
            if (tx_slow !== prev_tx && ((k - 1) % CPB_SLOW) != 0) edge_err++;
            if (tx_slow !== refLine(8'h00, k - 1, CPB_SLOW) || done_slow !== 1'b0) err_cnt++;
            if (busy_slow === 1'b1) busy_cnt++;
            prev_tx = tx_slow;
            tick();
        end
        checkOutput("slow_edge_alignment", edge_err, 0);
        checkOutput("slow_wave_errors", err_cnt, 0);
        checkOutput("slow_busy_cycles", busy_cnt, MSG_SLOW);
        checkOutput("slow_done_tx_busy", {29'd0, done_slow, tx_slow, busy_slow}, 32'b110);
        tick();
        checkOutput("slow_done_one_cycle", done_slow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
